// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared sizes and writeback source encoding for the register-bank scoreboard
package regbank_pkg;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/regbank_wb_arbiter.sv
// rtl/regbank_wb_arbiter.sv - fixed-priority mux of load returns over ALU writebacks onto the single bank write port
module regbank_wb_arbiter
  import regbank_pkg::*;
(
  input  logic              reset,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [REG_AW-1:0] alu_wb_addr,
  input  logic              alu_wb_high,
  input  logic              mem_wb_valid,
  input  logic [REG_AW-1:0] mem_wb_addr,
  output logic              write_back,
  output logic              we,
  output logic              we_high,
  output logic              read_mem,
  output logic [REG_AW-1:0] addr_d
);
  wb_src_e src;

  // Load returns cannot be back-pressured, so they always win the port
  always_comb begin
    src = WB_NONE;
    if (!reset) begin
      if (mem_wb_valid) begin
        src = WB_MEM;
      end else if (alu_wb_valid) begin
        src = WB_ALU;
      end
    end
  end

  assign alu_wb_ready = !reset && !mem_wb_valid;

  always_comb begin
    write_back = 1'b0;
    we         = 1'b0;
    we_high    = 1'b0;
    read_mem   = 1'b0;
    case (src)
      WB_MEM:  addr_d = mem_wb_addr;
      WB_ALU:  addr_d = alu_wb_addr;
      default: addr_d = '0;
    endcase
    // r0 is hardwired zero: a writeback aimed at it is swallowed entirely
    if (src != WB_NONE && addr_d != '0) begin
      write_back = 1'b1;
      we         = 1'b1;
      read_mem   = (src == WB_MEM);
      we_high    = (src == WB_ALU) && alu_wb_high;
    end
  end
endmodule

// File: rtl/regbank_scoreboard.sv
// rtl/regbank_scoreboard.sv - issue-side hazard scoreboard and write-port control for the 16x32 register bank
module regbank_scoreboard #(
  parameter int NUM_REGS    = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [regbank_pkg::REG_AW-1:0]     issue_addr_a,
  input  logic [regbank_pkg::REG_AW-1:0]     issue_addr_b,
  input  logic [regbank_pkg::REG_AW-1:0]     issue_addr_d,
  input  logic                               issue_we,
  output logic                               get_regs,
  output logic [regbank_pkg::REG_AW-1:0]     addr_a,
  output logic [regbank_pkg::REG_AW-1:0]     addr_b,
  input  logic                               alu_wb_valid,
  output logic                               alu_wb_ready,
  input  logic [regbank_pkg::REG_AW-1:0]     alu_wb_addr,
  input  logic [regbank_pkg::DATA_W-1:0]     alu_wb_data,
  input  logic                               alu_wb_high,
  input  logic                               mem_wb_valid,
  input  logic [regbank_pkg::REG_AW-1:0]     mem_wb_addr,
  output logic                               write_back,
  output logic                               we,
  output logic                               we_high,
  output logic                               read_mem,
  output logic [regbank_pkg::REG_AW-1:0]     addr_d,
  output logic [regbank_pkg::DATA_W-1:0]     data_d,
  output logic [NUM_REGS-1:0]                pending,
  output logic [STALL_CNT_W-1:0]             stall_cnt,
  output logic                               wb_err
);
  import regbank_pkg::*;

  localparam logic [NUM_REGS-1:0]    R0_BIT  = NUM_REGS'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic                hazard;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Only registered pending bits are checked, so a register freed at edge N
  // becomes issuable in cycle N+1, after the bank write has landed
  assign hazard = pending[issue_addr_a] || pending[issue_addr_b] ||
                  (issue_we && pending[issue_addr_d]);

  assign issue_ready = !reset && !hazard;
  assign get_regs    = issue_valid && issue_ready;
  assign addr_a      = issue_addr_a;
  assign addr_b      = issue_addr_b;
  assign data_d      = alu_wb_data;

  regbank_wb_arbiter u_wb_arbiter (
    .reset        (reset),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_high  (alu_wb_high),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_addr  (mem_wb_addr),
    .write_back   (write_back),
    .we           (we),
    .we_high      (we_high),
    .read_mem     (read_mem),
    .addr_d       (addr_d)
  );

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (get_regs && issue_we) begin
      set_vec[issue_addr_d] = 1'b1;
    end
    if (write_back) begin
      clr_vec[addr_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      pending <= ((pending & ~clr_vec) | set_vec) & ~R0_BIT;
      if (issue_valid && !issue_ready && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (write_back && !pending[addr_d]) begin
        wb_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regbank_scoreboard.sv
// tb/tb_regbank_scoreboard.sv - directed plus randomized bench for regbank_scoreboard against a register-set model
module tb_regbank_scoreboard;
  logic        clk = 1'b0;
  logic        reset, issue_valid, issue_ready, issue_we, get_regs;
  logic [3:0]  issue_addr_a, issue_addr_b, issue_addr_d, addr_a, addr_b;
  logic        alu_wb_valid, alu_wb_ready, alu_wb_high, mem_wb_valid;
  logic [3:0]  alu_wb_addr, mem_wb_addr, addr_d;
  logic [31:0] alu_wb_data, data_d;
  logic        write_back, we, we_high, read_mem, wb_err;
  logic [15:0] pending, stall_cnt;

  always #5 clk = ~clk;

  regbank_scoreboard #(.NUM_REGS(16), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_addr_a(issue_addr_a), .issue_addr_b(issue_addr_b),
    .issue_addr_d(issue_addr_d), .issue_we(issue_we),
    .get_regs(get_regs), .addr_a(addr_a), .addr_b(addr_b),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data), .alu_wb_high(alu_wb_high),
    .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr),
    .write_back(write_back), .we(we), .we_high(we_high), .read_mem(read_mem),
    .addr_d(addr_d), .data_d(data_d),
    .pending(pending), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: set of registers awaiting a write, sticky error, stall count
  bit busy [16];
  bit m_err;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [15:0] busy_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = busy[i];
    return v;
  endfunction

  function automatic logic [3:0] pick_wb();
    int cands[$];
    for (int i = 1; i < 16; i++) if (busy[i]) cands.push_back(i);
    if (cands.size() != 0 && $urandom_range(0, 9) != 0)
      return 4'(cands[$urandom_range(0, cands.size() - 1)]);
    return 4'($urandom_range(0, 15));
  endfunction

  // One clock cycle: drive, check combinational outputs mid-cycle, clock, check registers
  task automatic apply(input logic rst, input logic iv, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic iwe, input logic av, input logic [3:0] aaddr,
                       input logic [31:0] adata, input logic ah, input logic mv, input logic [3:0] maddr);
    bit rdy, gt, sel_mem, sel_alu, wb;
    logic [3:0] waddr;
    reset = rst; issue_valid = iv; issue_addr_a = a; issue_addr_b = b; issue_addr_d = d;
    issue_we = iwe; alu_wb_valid = av; alu_wb_addr = aaddr; alu_wb_data = adata;
    alu_wb_high = ah; mem_wb_valid = mv; mem_wb_addr = maddr;
    #4;
    rdy     = !rst && !(busy[a] || busy[b] || (iwe && busy[d]));
    gt      = iv && rdy;
    sel_mem = !rst && mv;
    sel_alu = !rst && !mv && av;
    waddr   = sel_mem ? maddr : aaddr;
    wb      = (sel_mem || sel_alu) && waddr != 4'd0;
    check("issue_ready", issue_ready, rdy);
    check("get_regs", get_regs, gt);
    check("addr_a", addr_a, a);
    check("addr_b", addr_b, b);
    check("alu_wb_ready", alu_wb_ready, !rst && !mv);
    check("write_back", write_back, wb);
    check("we", we, wb);
    check("we_high", we_high, wb && sel_alu && ah);
    check("read_mem", read_mem, wb && sel_mem);
    check("data_d", data_d, adata);
    if (wb) check("addr_d", addr_d, waddr);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) busy[i] = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if (iv && !rdy && m_cnt < 65535) m_cnt++;
      if (wb) begin
        if (!busy[waddr]) m_err = 1'b1;
        busy[waddr] = 1'b0;
      end
      if (gt && iwe && d != 4'd0) busy[d] = 1'b1;
    end
    #1;
    check("pending", pending, busy_vec());
    check("wb_err", wb_err, m_err);
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  initial begin
    int n1;
    m_err = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1;

    // Reset held with an instruction and a writeback presented
    repeat (3) apply(1, 1, 4'd1, 4'd2, 4'd3, 1, 1, 4'd6, 32'h1234, 1, 0, 4'd0);
    check("rst_pending", pending, 16'h0000);

    apply(0, 1, 4'd1, 4'd2, 4'd3, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    check("first_issue_pending", pending, 16'h0008);

    // RAW on r3 stalls until the ALU writeback lands
    repeat (3) apply(0, 1, 4'd3, 4'd0, 4'd4, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    check("raw_stall_cnt", stall_cnt, 16'd3);
    apply(0, 1, 4'd3, 4'd0, 4'd4, 1, 1, 4'd3, 32'hCAFE0003, 0, 0, 4'd0);
    check("raw_cleared", pending, 16'h0000);
    apply(0, 1, 4'd3, 4'd0, 4'd4, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    check("raw_issue_after", pending, 16'h0010);

    // Load return beats a simultaneous ALU writeback
    apply(0, 1, 4'd0, 4'd0, 4'd5, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    apply(0, 1, 4'd0, 4'd0, 4'd6, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd6, 32'hBEEF0006, 1, 1, 4'd5);
    check("mem_first_pending", pending, 16'h0050);
    apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd6, 32'hBEEF0006, 1, 0, 4'd0);
    check("alu_second_pending", pending, 16'h0010);

    // r0 never tracked; stray writeback sets the sticky error
    apply(0, 1, 4'd0, 4'd0, 4'd0, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd0, 32'h11, 0, 0, 4'd0);
    check("r0_wb_no_err", wb_err, 1'b0);
    apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd7, 32'h77, 0, 0, 4'd0);
    repeat (2) apply(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    check("wb_err_sticky", wb_err, 1'b1);
    apply(1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    check("wb_err_reset", wb_err, 1'b0);

    // Randomized traffic with occasional mid-operation reset
    for (int k = 0; k < 400; k++) begin
      apply($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 1'($urandom), $urandom_range(0, 1) == 0, pick_wb(), $urandom,
            1'($urandom), $urandom_range(0, 3) == 0, pick_wb());
    end

    // Permanent hazard drives the stall counter into saturation
    apply(1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    apply(0, 1, 4'd0, 4'd0, 4'd9, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    apply(0, 1, 4'd9, 4'd0, 4'd10, 1, 0, 4'd0, 32'h0, 0, 0, 4'd0);
    n1 = 65534 - m_cnt;
    repeat (n1) @(posedge clk);
    #1;
    check("stall_cnt_fffe", stall_cnt, 16'hFFFE);
    @(posedge clk);
    #1;
    check("stall_cnt_ffff", stall_cnt, 16'hFFFF);
    repeat (4500) @(posedge clk);
    #1;
    check("stall_cnt_sat", stall_cnt, 16'hFFFF);
    check("sat_pending", pending, 16'h0200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regbank_scoreboard.md
# regbank_scoreboard

Issue-side scheduler for the 16×32 register bank: tracks which destination registers have an outstanding write, stalls instruction issue on RAW/WAW hazards, and arbitrates the single write port between the ALU writeback path and memory load returns. It sits between decode and the register bank, driving the bank's read strobe, its read addresses and all of its write controls.

## Interface
- NUM_REGS, 16, register count; register 0 is hardwired zero and never tracked.
- STALL_CNT_W, 16, width of the saturating stall counter.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  instruction accepted on this edge if issue_valid is also high.
- issue_addr_a, issue_addr_b  in  4  source registers.
- issue_addr_d  in  4  destination register.
- issue_we  in  1  instruction writes addr_d.
- get_regs  out  1  register-bank read strobe, equal to issue_valid & issue_ready.
- addr_a, addr_b  out  4  register-bank read addresses, passed through from issue_addr_a/b.
- alu_wb_valid, alu_wb_ready  in/out  1  ALU writeback handshake.
- alu_wb_addr  in  4.
- alu_wb_data  in  32.
- alu_wb_high  in  1  upper-half-only write.
- mem_wb_valid  in  1  load return; this request has no ready and must be taken in the same cycle.
- mem_wb_addr  in  4.
- write_back, we, we_high, read_mem  out  1  register-bank write controls.
- addr_d  out  4.
- data_d  out  32  register-bank write address and ALU data.
- pending  out  16  scoreboard vector; bit 0 is always 0.
- stall_cnt  out  STALL_CNT_W  count of cycles with issue_valid & !issue_ready.
- wb_err  out  1  sticky; set by a writeback to a register that is not pending.

## Operation
- hazard is true when any of these bits is set: pending[issue_addr_a], pending[issue_addr_b], or pending[issue_addr_d] with issue_we. The check uses the registered pending bits only.
- issue_ready = !reset & !hazard.
- Accept with issue_we=1 and issue_addr_d≠0 sets pending[addr_d] at the edge.
- Write-port arbitration: mem_wb_valid has fixed priority.
  - alu_wb_ready = !reset & !mem_wb_valid.
  - Selected source drives write_back=1 and we=1.
  - read_mem=1 for a memory return.
  - we_high=alu_wb_high for an ALU write and 0 for a memory return.
  - addr_d is taken from the selected source.
  - data_d=alu_wb_data in all cases.
  - With no source selected, write_back, we, we_high and read_mem are all 0.
- A writeback to addr≠0 clears pending[addr] at the same edge. If that bit was already 0, wb_err is set. A writeback to addr 0 is dropped (write_back=0) and does not set wb_err.
- Simultaneous set and clear of the same register cannot occur, because WAW stalls the issue.
- stall_cnt increments once per stalled cycle and saturates at all-ones.
- Reset mid-operation clears pending, wb_err and stall_cnt. Outstanding loads are abandoned; the memory side must also be reset.

## Timing
- Reset values: pending=0, stall_cnt=0, wb_err=0, issue_ready=0, alu_wb_ready=0. get_regs, write_back, we, we_high and read_mem are all 0 during reset.
- All outputs except the registers pending, stall_cnt and wb_err are combinational from registered state and the current inputs.
- The bank read is registered, so data_a/data_b are valid one cycle after get_regs.
- A register cleared at edge N can be issued against in cycle N+1, not earlier. This keeps reads from sampling stale bank contents, because a same-edge write is not visible to a same-edge read.
- Issue-to-issue throughput is one per cycle when there are no hazards.
- Minimum dependent-issue gap: producer accepted at edge E, writeback at edge W ≥ E+1, consumer accepted at edge ≥ W+1.

## Structure
- Package regbank_pkg holds NUM_REGS, REG_AW=4 and DATA_W=32, plus the writeback source encoding (WB_NONE, WB_ALU, WB_MEM).
- One sub-module, regbank_wb_arbiter: a combinational two-source priority mux producing the write controls and the clear address.
- The scoreboard register, the hazard check and the counters stay in the top module.

## Test plan
- Reset held for 3 cycles with issue_valid=1 → issue_ready=0, get_regs=0, pending=0. After release, issue of r1,r2→r3 is accepted and pending=16'h0008.
- Issue r3←…, then r4←r3 the next cycle → second issue stalls and stall_cnt counts. ALU writeback to r3 at edge W → pending[3]=0 at W, and r4←r3 is accepted at edge W+1 with get_regs=1.
- mem_wb_valid and alu_wb_valid in the same cycle (addrs 5 and 6) → write_back with read_mem=1 and addr_d=5, alu_wb_ready=0. Next cycle the ALU write to 6 completes with we_high following alu_wb_high.
- Issue with addr_d=0 and issue_we=1 → pending stays 0. Writeback to r0 → write_back=0 and wb_err=0. ALU writeback to non-pending r7 → wb_err=1, sticky until reset.
- Hold issue_valid with a permanent hazard for 70000 cycles → stall_cnt saturates at 16'hFFFF.
